lsu: RTL and testbench
======================

# lsu

Load/store unit for the RISC-V core's memory stage. It consumes the ALU's 32-bit result as the effective address, along with the store operand and funct3. It issues byte-lane-aligned requests to the data memory over a valid/ready handshake, then returns a sign- or zero-extended load value, a store completion, or an error to writeback. It handles one transaction at a time.

## Interface
- `RSP_TIMEOUT`, default 64: number of cycles in WAIT_RSP with no `mem_rsp_valid` before the load is aborted with an error; must be ≥ 2.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  transaction request from execute.
- `req_ready`  out  1  high only in IDLE; the request is accepted on `req_valid && req_ready`.
- `req_is_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  32  effective address (ALU result).
- `req_wdata`  in  32  store operand, taken from its low bits.
- `mem_req_valid`  out  1  memory request.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  32  word address; `[1:0]` is always 00.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_wstrb`  out  4  byte strobes; 0000 on loads.
- `mem_rsp_valid`  in  1  load data valid.
- `mem_rdata`  in  32  load word.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_data`  out  32  extended load value; 0 for stores and errors.
- `rsp_err`  out  1  misaligned access, illegal funct3, or timeout.

## Operation
- States: IDLE, REQ, WAIT_RSP, DONE.
- **IDLE:** on accept, capture all `req_*` fields.
  - If the access is illegal, go to DONE with error.
  - Otherwise go to REQ.
- **Illegal accesses:**
  - H/HU with `addr[0]` = 1.
  - W with `addr[1:0]` ≠ 00.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 not in {000, 001, 010}.
- **REQ:** drive `mem_req_valid`, and hold every `mem_*` output stable until `mem_req_ready`.
  - On handshake, a store goes to DONE.
  - On handshake, a load goes to WAIT_RSP and clears the timeout counter.
- **WAIT_RSP:** on `mem_rsp_valid`, register the extended data and go to DONE.
  - The counter increments each cycle. When it reaches `RSP_TIMEOUT`, go to DONE with `rsp_err` = 1.
  - `mem_rsp_valid` is ignored in every other state.
- **DONE:** `rsp_valid` = 1 for exactly one cycle, then go to IDLE. Writeback cannot stall this pulse.
- **Store lanes** (`lane` = `addr[1:0]`):
  - SB: `mem_wdata` = {4{wdata[7:0]}}, `mem_wstrb` = 0001 << lane.
  - SH: `mem_wdata` = {2{wdata[15:0]}}, `mem_wstrb` = 0011 << (2·`addr[1]`).
  - SW: `mem_wdata` = wdata, `mem_wstrb` = 1111.
- **Load extraction:**
  - B/BU take byte `lane`.
  - H/HU take halfword `addr[1]`.
  - B and H are sign-extended from the top bit; BU and HU are zero-extended.
- `mem_addr` = {addr[31:2], 2'b00}.

## Timing
- **Reset values:**
  - State IDLE; `req_ready` = 1.
  - `mem_req_valid`, `mem_we`, `rsp_valid`, `rsp_err` = 0.
  - `mem_addr`, `mem_wdata`, `rsp_data` = 0; `mem_wstrb` = 0000.
- **Load latency:** accept at cycle 0, request at cycle 1, zero-wait response at cycle 2, `rsp_valid` at cycle 3.
- **Store latency:** accept at cycle 0, request at cycle 1, `rsp_valid` at cycle 2.
- **Error latency:** an illegal access gives `rsp_valid` with `rsp_err` at cycle 1 and never asserts `mem_req_valid`.
- **Back-pressure:** each `mem_req_ready` low cycle adds one cycle of latency.
- **Timeout:** WAIT_RSP lasts at most `RSP_TIMEOUT` cycles.
- **Request handshake:** `req_ready` is low from the cycle after accept until IDLE is re-entered. The next accept can occur in the cycle after `rsp_valid`.
- **Response arrival:** memory responds at least one cycle after the request handshake. A response in the same cycle as the handshake is ignored.
- **Late response:** a response arriving after a timeout is dropped and must not disturb the next transaction.
- **Reset mid-transaction:** asserting `rst_n` low forces all outputs to their reset values immediately, regardless of `clk`. No `rsp_valid` is produced for the abandoned transaction.

## Test plan
- **Misaligned LH:** `req_addr` = 0x1001, funct3 001 → `rsp_err` = 1 one cycle after accept; `mem_req_valid` never asserts.
- **SB, lane 2:** `req_addr` = 0x1002, wdata = 0xDEADBEA5 → `mem_addr` = 0x1000, `mem_wdata` = 0xA5A5A5A5, `mem_wstrb` = 0100, `rsp_valid` at cycle 2.
- **LB vs LBU, lane 3:** `mem_rdata` = 0x80FF7F01, `req_addr` = 0x2003 → LB returns 0xFFFFFF80; LBU returns 0x00000080.
- **LHU under back-pressure:** `req_addr` = 0x2002, `mem_req_ready` low for 3 cycles, `mem_rdata` = 0x9ABC1234 → `mem_*` outputs stable throughout; `rsp_data` = 0x00009ABC at cycle 6.
- **Timeout:** LW with `RSP_TIMEOUT` = 4 and no response → `rsp_err` = 1 after 4 WAIT_RSP cycles. A stray `mem_rsp_valid` in the next cycle is ignored, and a following SW completes normally.
- **Reset mid-load:** pull `rst_n` low in WAIT_RSP → all outputs go to reset values immediately. After release, `req_ready` = 1 and no `rsp_valid` appears.

Source files
------------

// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// A request is a single word-aligned beat with byte strobes. Load data returns
// on a separate valid pulse that carries no backpressure.
interface lsu_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit for the memory stage. It handles one transaction at a time.
// It issues a byte-lane-aligned request to data memory and returns an extended
// load value, a store completion, or an error.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a request from execute
// REQ      | memory request presented, held until mem_req_ready
// WAIT_RSP | load issued, waiting for mem_rsp_valid or a timeout
// DONE     | one-cycle completion pulse to writeback
module lsu #(
  parameter int RSP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  lsu_if.master       mem,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  localparam int CW = $clog2(RSP_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RSP_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t        state_q, state_d;
  logic          accept;
  logic          illegal;
  logic [31:0]   st_wdata;
  logic [3:0]    st_wstrb;
  logic [31:0]   ld_ext;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  logic [2:0]    funct3_q;
  logic [1:0]    lane_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   data_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;

  assign mem.mem_req_valid = (state_q == REQ);
  assign mem.mem_we        = we_q;
  assign mem.mem_addr      = addr_q;
  assign mem.mem_wdata     = wdata_q;
  assign mem.mem_wstrb     = wstrb_q;

  // Classify the incoming request. Unknown widths and unsigned stores are
  // rejected along with misaligned halfwords and words.
  always_comb begin
    illegal = 1'b1;
    case (req_funct3)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = req_addr[0];
      3'b010:  illegal = |req_addr[1:0];
      3'b100:  illegal = req_is_store;
      3'b101:  illegal = req_is_store || req_addr[0];
      default: illegal = 1'b1;
    endcase
  end

  // Replicate store data across lanes and select the byte strobes. A load
  // drives no data and no strobes.
  always_comb begin
    st_wdata = 32'h0;
    st_wstrb = 4'b0000;
    if (req_is_store) begin
      case (req_funct3)
        3'b000: begin
          st_wdata = {4{req_wdata[7:0]}};
          st_wstrb = 4'b0001 << req_addr[1:0];
        end
        3'b001: begin
          st_wdata = {2{req_wdata[15:0]}};
          st_wstrb = 4'b0011 << {req_addr[1], 1'b0};
        end
        3'b010: begin
          st_wdata = req_wdata;
          st_wstrb = 4'b1111;
        end
        default: begin
          st_wdata = 32'h0;
          st_wstrb = 4'b0000;
        end
      endcase
    end
  end

  // Pick the addressed byte or halfword from the load word and extend it.
  always_comb begin
    ld_byte = mem.mem_rdata[7:0];
    case (lane_q)
      2'd0: ld_byte = mem.mem_rdata[7:0];
      2'd1: ld_byte = mem.mem_rdata[15:8];
      2'd2: ld_byte = mem.mem_rdata[23:16];
      2'd3: ld_byte = mem.mem_rdata[31:24];
      default: ld_byte = mem.mem_rdata[7:0];
    endcase
    ld_half = lane_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = mem.mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. A response in the final WAIT_RSP cycle takes priority
  // over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = illegal ? DONE : REQ;
      REQ:      if (mem.mem_req_ready) state_d = we_q ? DONE : WAIT_RSP;
      WAIT_RSP: if (mem.mem_rsp_valid || (cnt_q == CNT_LAST)) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Capture the request, track the response timer and build the completion.
  // Results are cleared on leaving DONE, so rsp_data and rsp_err read zero
  // outside the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q <= 3'b000;
      lane_q   <= 2'b00;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'b0000;
      data_q   <= 32'h0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            funct3_q <= req_funct3;
            lane_q   <= req_addr[1:0];
            we_q     <= req_is_store;
            addr_q   <= {req_addr[31:2], 2'b00};
            wdata_q  <= st_wdata;
            wstrb_q  <= st_wstrb;
            data_q   <= 32'h0;
            err_q    <= illegal;
          end
        end
        REQ: begin
          if (mem.mem_req_ready) cnt_q <= '0;
        end
        WAIT_RSP: begin
          if (mem.mem_rsp_valid) begin
            data_q <= ld_ext;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) err_q <= 1'b1;
          end
        end
        DONE: begin
          data_q <= 32'h0;
          err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu with hand-computed expected values.
module tb_lsu;
  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int n_chk;
  int n_err;

  lsu_if mem_bus ();

  lsu #(.RSP_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .mem          (mem_bus.master),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus(input string tag, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                         input logic [3:0] e_strb, input logic e_we);
    chk($sformatf("%s.mem_req_valid", tag), 32'(mem_bus.mem_req_valid), 32'd1);
    chk($sformatf("%s.mem_addr", tag), mem_bus.mem_addr, e_addr);
    chk($sformatf("%s.mem_wdata", tag), mem_bus.mem_wdata, e_wdata);
    chk($sformatf("%s.mem_wstrb", tag), 32'(mem_bus.mem_wstrb), 32'(e_strb));
    chk($sformatf("%s.mem_we", tag), 32'(mem_bus.mem_we), 32'(e_we));
  endtask

  task automatic drive_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input int stall,
                         input logic [31:0] e_addr, input logic [31:0] e_data);
    drive_req(1'b0, f3, addr, 32'hFFFF_FFFF);
    mem_bus.mem_req_ready = (stall == 0);
    chk($sformatf("%s.req_ready", tag), 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      chk_bus($sformatf("%s.stall%0d", tag, i), e_addr, 32'h0, 4'b0000, 1'b0);
      chk($sformatf("%s.stall_req_ready", tag), 32'(req_ready), 32'd0);
      tick();
    end
    // A response coinciding with the request handshake must be ignored.
    mem_bus.mem_req_ready = 1'b1;
    mem_bus.mem_rsp_valid = 1'b1;
    mem_bus.mem_rdata     = 32'h5A5A_5A5A;
    chk_bus($sformatf("%s.hs", tag), e_addr, 32'h0, 4'b0000, 1'b0);
    tick();
    mem_bus.mem_req_ready = 1'b0;
    mem_bus.mem_rdata     = rdata;
    chk($sformatf("%s.wait_req_valid", tag), 32'(mem_bus.mem_req_valid), 32'd0);
    chk($sformatf("%s.wait_rsp_valid", tag), 32'(rsp_valid), 32'd0);
    tick();
    mem_bus.mem_rsp_valid = 1'b0;
    mem_bus.mem_rdata     = 32'h0;
    chk($sformatf("%s.rsp_valid", tag), 32'(rsp_valid), 32'd1);
    chk($sformatf("%s.rsp_data", tag), rsp_data, e_data);
    chk($sformatf("%s.rsp_err", tag), 32'(rsp_err), 32'd0);
    tick();
    chk($sformatf("%s.pulse_end", tag), 32'(rsp_valid), 32'd0);
    chk($sformatf("%s.idle_ready", tag), 32'(req_ready), 32'd1);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int stall, input logic [31:0] e_addr,
                          input logic [31:0] e_wdata, input logic [3:0] e_strb);
    drive_req(1'b1, f3, addr, wdata);
    mem_bus.mem_req_ready = (stall == 0);
    chk($sformatf("%s.req_ready", tag), 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      chk_bus($sformatf("%s.stall%0d", tag, i), e_addr, e_wdata, e_strb, 1'b1);
      tick();
    end
    mem_bus.mem_req_ready = 1'b1;
    chk_bus($sformatf("%s.hs", tag), e_addr, e_wdata, e_strb, 1'b1);
    chk($sformatf("%s.early_rsp", tag), 32'(rsp_valid), 32'd0);
    tick();
    mem_bus.mem_req_ready = 1'b0;
    chk($sformatf("%s.rsp_valid", tag), 32'(rsp_valid), 32'd1);
    chk($sformatf("%s.rsp_err", tag), 32'(rsp_err), 32'd0);
    chk($sformatf("%s.rsp_data", tag), rsp_data, 32'h0);
    chk($sformatf("%s.done_req_valid", tag), 32'(mem_bus.mem_req_valid), 32'd0);
    tick();
    chk($sformatf("%s.pulse_end", tag), 32'(rsp_valid), 32'd0);
    chk($sformatf("%s.idle_ready", tag), 32'(req_ready), 32'd1);
  endtask

  task automatic do_illegal(input string tag, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr);
    drive_req(st, f3, addr, 32'h1234_5678);
    mem_bus.mem_req_ready = 1'b1;
    chk($sformatf("%s.req_ready", tag), 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk($sformatf("%s.rsp_valid", tag), 32'(rsp_valid), 32'd1);
    chk($sformatf("%s.rsp_err", tag), 32'(rsp_err), 32'd1);
    chk($sformatf("%s.rsp_data", tag), rsp_data, 32'h0);
    chk($sformatf("%s.mem_req_valid", tag), 32'(mem_bus.mem_req_valid), 32'd0);
    tick();
    mem_bus.mem_req_ready = 1'b0;
    chk($sformatf("%s.pulse_end", tag), 32'(rsp_valid), 32'd0);
    chk($sformatf("%s.err_end", tag), 32'(rsp_err), 32'd0);
    chk($sformatf("%s.no_req", tag), 32'(mem_bus.mem_req_valid), 32'd0);
    chk($sformatf("%s.idle_ready", tag), 32'(req_ready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk($sformatf("%s.req_ready", tag), 32'(req_ready), 32'd1);
    chk($sformatf("%s.mem_req_valid", tag), 32'(mem_bus.mem_req_valid), 32'd0);
    chk($sformatf("%s.mem_we", tag), 32'(mem_bus.mem_we), 32'd0);
    chk($sformatf("%s.mem_addr", tag), mem_bus.mem_addr, 32'h0);
    chk($sformatf("%s.mem_wdata", tag), mem_bus.mem_wdata, 32'h0);
    chk($sformatf("%s.mem_wstrb", tag), 32'(mem_bus.mem_wstrb), 32'd0);
    chk($sformatf("%s.rsp_valid", tag), 32'(rsp_valid), 32'd0);
    chk($sformatf("%s.rsp_data", tag), rsp_data, 32'h0);
    chk($sformatf("%s.rsp_err", tag), 32'(rsp_err), 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_is_store = 1'b0;
    req_funct3 = 3'b000;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    mem_bus.mem_req_ready = 1'b0;
    mem_bus.mem_rsp_valid = 1'b0;
    mem_bus.mem_rdata = 32'h0;

    #3;
    chk_reset_outputs("reset");
    #10;
    rst_n = 1'b1;
    tick();
    tick();

    do_illegal("lh_misaligned", 1'b0, 3'b001, 32'h0000_1001);
    do_illegal("lw_misaligned", 1'b0, 3'b010, 32'h0000_2002);
    do_illegal("load_f3_011", 1'b0, 3'b011, 32'h0000_2000);
    do_illegal("store_f3_100", 1'b1, 3'b100, 32'h0000_1000);

    do_store("sb_lane2", 3'b000, 32'h0000_1002, 32'hDEAD_BEA5, 0,
             32'h0000_1000, 32'hA5A5_A5A5, 4'b0100);
    do_store("sh_upper", 3'b001, 32'h0000_1006, 32'hCAFE_BEEF, 2,
             32'h0000_1004, 32'hBEEF_BEEF, 4'b1100);

    do_load("lb_lane3", 3'b000, 32'h0000_2003, 32'h80FF_7F01, 0, 32'h0000_2000, 32'hFFFF_FF80);
    do_load("lbu_lane3", 3'b100, 32'h0000_2003, 32'h80FF_7F01, 0, 32'h0000_2000, 32'h0000_0080);
    do_load("lb_lane1", 3'b000, 32'h0000_2001, 32'h80FF_7F01, 0, 32'h0000_2000, 32'h0000_007F);
    do_load("lhu_bp", 3'b101, 32'h0000_2002, 32'h9ABC_1234, 3, 32'h0000_2000, 32'h0000_9ABC);
    do_load("lh_lower", 3'b001, 32'h0000_2000, 32'h1234_8001, 0, 32'h0000_2000, 32'hFFFF_8001);
    do_load("lw", 3'b010, 32'h0000_2004, 32'h89AB_CDEF, 1, 32'h0000_2004, 32'h89AB_CDEF);

    // Timeout with RSP_TIMEOUT = 4, then a stray response and a normal SW.
    drive_req(1'b0, 3'b010, 32'h0000_3000, 32'h0);
    mem_bus.mem_req_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("to.req_valid", 32'(mem_bus.mem_req_valid), 32'd1);
    tick();
    mem_bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to.wait%0d", i), 32'(rsp_valid), 32'd0);
      tick();
    end
    chk("to.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to.rsp_err", 32'(rsp_err), 32'd1);
    chk("to.rsp_data", rsp_data, 32'h0);
    tick();
    mem_bus.mem_rsp_valid = 1'b1;
    mem_bus.mem_rdata = 32'h1111_1111;
    chk("to.stray_idle", 32'(rsp_valid), 32'd0);
    chk("to.stray_ready", 32'(req_ready), 32'd1);
    drive_req(1'b1, 3'b010, 32'h0000_3004, 32'h1234_5678);
    mem_bus.mem_req_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    mem_bus.mem_rsp_valid = 1'b0;
    mem_bus.mem_rdata = 32'h0;
    chk_bus("to.sw", 32'h0000_3004, 32'h1234_5678, 4'b1111, 1'b1);
    tick();
    mem_bus.mem_req_ready = 1'b0;
    chk("to.sw_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to.sw_rsp_err", 32'(rsp_err), 32'd0);
    tick();
    chk("to.sw_pulse_end", 32'(rsp_valid), 32'd0);

    // Reset asserted while waiting for load data.
    drive_req(1'b0, 3'b010, 32'h0000_4000, 32'h0);
    mem_bus.mem_req_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    mem_bus.mem_req_ready = 1'b0;
    chk("rst.in_wait", 32'(rsp_valid), 32'd0);
    chk("rst.addr_before", mem_bus.mem_addr, 32'h0000_4000);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    mem_bus.mem_rsp_valid = 1'b1;
    mem_bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst.no_rsp%0d", i), 32'(rsp_valid), 32'd0);
      chk($sformatf("rst.ready%0d", i), 32'(req_ready), 32'd1);
      chk($sformatf("rst.no_req%0d", i), 32'(mem_bus.mem_req_valid), 32'd0);
      mem_bus.mem_rsp_valid = 1'b0;
      tick();
    end

    do_load("post_rst_lbu", 3'b100, 32'h0000_5001, 32'h0000_C300, 0, 32'h0000_5000, 32'h0000_00C3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
